// File: rtl/rs_credit_dispatcher_pkg.sv
// rs_credit_dispatcher_pkg: RS type codes and default sizing shared by the dispatcher slice
package rs_credit_dispatcher_pkg;
    localparam int RS_ENT_SEL         = 3;
    localparam int RS_DEPTH_DEF       = 8;
    localparam int NUM_RS_DEF         = 4;
    localparam int DISPATCH_WIDTH_DEF = 2;
    typedef enum logic [RS_ENT_SEL-1:0] {
        RS_ENT_NONE   = 3'd0,
        RS_ENT_ALU    = 3'd1,
        RS_ENT_BRANCH = 3'd2,
        RS_ENT_MUL    = 3'd3,
        RS_ENT_LDST   = 3'd4
    } rs_ent_e;
endpackage

// File: rtl/rs_credit_dispatcher_if.sv
// rs_credit_dispatcher_if: dispatch-stage bundle between rename/upstream (master) and the dispatcher (slave)
interface rs_credit_dispatcher_if #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int NUM_RS         = 4,
    parameter int RS_DEPTH       = 8,
    parameter int SEL_W          = 3
);
    localparam int NW = $clog2(DISPATCH_WIDTH + 1);
    localparam int CW = $clog2(RS_DEPTH + 1);
    logic                             flush_i;
    logic [DISPATCH_WIDTH-1:0]        inst_valid_i;
    logic [DISPATCH_WIDTH*SEL_W-1:0]  inst_rs_type_i;
    logic [NUM_RS-1:0]                rs_release_i;
    logic [DISPATCH_WIDTH-1:0]        grant_o;
    logic [DISPATCH_WIDTH*NUM_RS-1:0] req_o;
    logic [NUM_RS*NW-1:0]             req_num_o;
    logic                             stall_o;
    logic [NUM_RS*CW-1:0]             credit_o;
    modport master (
        output flush_i, inst_valid_i, inst_rs_type_i, rs_release_i,
        input  grant_o, req_o, req_num_o, stall_o, credit_o
    );
    modport slave (
        input  flush_i, inst_valid_i, inst_rs_type_i, rs_release_i,
        output grant_o, req_o, req_num_o, stall_o, credit_o
    );
endinterface

// File: rtl/rs_credit_counter.sv
// rs_credit_counter: free-entry credit register for one RS with saturation, flush refill and overflow check
module rs_credit_counter #(
    parameter int RS_DEPTH       = 8,
    parameter int DISPATCH_WIDTH = 2,
    localparam int NW = $clog2(DISPATCH_WIDTH + 1),
    localparam int CW = $clog2(RS_DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,
    input  logic [NW-1:0] req_num_i,
    input  logic          release_i,
    output logic [CW-1:0] credit_o
);
    localparam int AW = CW + 1;
    logic [CW-1:0] credit_q, credit_d;
    logic [AW-1:0] sum;
    logic          ovf;
    // Consume this cycle's grants, return releases, clamp at depth; flush refills
    always_comb begin
        sum      = AW'(credit_q) - AW'(req_num_i) + AW'(release_i);
        ovf      = sum > AW'(RS_DEPTH);
        credit_d = (flush_i || ovf) ? CW'(RS_DEPTH) : sum[CW-1:0];
    end
    // Credit register, full on reset
    always_ff @(posedge clk_i) begin
        credit_q <= reset_i ? CW'(RS_DEPTH) : credit_d;
    end
    assign credit_o = credit_q;
`ifndef SYNTHESIS
    // A release into a full RS means the issue side lost track of occupancy
    always @(posedge clk_i) begin
        if (!reset_i && !flush_i) assert (!ovf) else $warning("rs_credit_counter: credit overflow, saturated at %0d", RS_DEPTH);
    end
`endif
endmodule

// File: rtl/rs_credit_dispatcher.sv
// rs_credit_dispatcher: in-order credit-checked RS dispatch grant; RS_CREDIT_BYPASS_EN lets same-cycle releases fund grants
module rs_credit_dispatcher
    import rs_credit_dispatcher_pkg::*;
#(
    parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_DEF,
    parameter int NUM_RS         = NUM_RS_DEF,
    parameter int RS_DEPTH       = RS_DEPTH_DEF,
    parameter int SEL_W          = RS_ENT_SEL
) (
    input logic                   clk_i,
    input logic                   reset_i,
    rs_credit_dispatcher_if.slave bus
);
    localparam int NW = $clog2(DISPATCH_WIDTH + 1);
    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam int AW = CW + 1;
    logic [NUM_RS*CW-1:0]             credit;
    logic [AW-1:0]                    avail [NUM_RS];
    logic [DISPATCH_WIDTH-1:0]        grant;
    logic [DISPATCH_WIDTH*NUM_RS-1:0] req;
    logic [NUM_RS*NW-1:0]             req_num;
    // Entries each RS can accept this cycle
    always_comb begin
        for (int r = 0; r < NUM_RS; r++) begin
`ifdef RS_CREDIT_BYPASS_EN
            avail[r] = AW'(credit[r*CW +: CW]) + AW'(bus.rs_release_i[r]);
`else
            avail[r] = AW'(credit[r*CW +: CW]);
`endif
        end
    end
    // Walk slots oldest first; the first valid slot without room closes the prefix
    always_comb begin
        logic              open;
        logic [NUM_RS-1:0] sel;
        logic [NUM_RS-1:0] room;
        logic [NW-1:0]     cnt [NUM_RS];
        grant = '0;
        req   = '0;
        open  = 1'b1;
        sel   = '0;
        room  = '0;
        for (int r = 0; r < NUM_RS; r++) cnt[r] = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            for (int r = 0; r < NUM_RS; r++) begin
                sel[r]  = bus.inst_rs_type_i[i*SEL_W +: SEL_W] == SEL_W'(r + 1);
                room[r] = avail[r] > AW'(cnt[r]);
            end
            if (bus.inst_valid_i[i]) begin
                if (open && (sel == '0 || (sel & room) != '0)) begin
                    grant[i] = 1'b1;
                    req[i*NUM_RS +: NUM_RS] = sel;
                    for (int r = 0; r < NUM_RS; r++) cnt[r] = cnt[r] + NW'(sel[r]);
                end else begin
                    open = 1'b0;
                end
            end
        end
        if (bus.flush_i) begin
            grant = '0;
            req   = '0;
            for (int r = 0; r < NUM_RS; r++) cnt[r] = '0;
        end
        for (int r = 0; r < NUM_RS; r++) req_num[r*NW +: NW] = cnt[r];
    end
    for (genvar g = 0; g < NUM_RS; g++) begin : g_rs
        rs_credit_counter #(.RS_DEPTH(RS_DEPTH), .DISPATCH_WIDTH(DISPATCH_WIDTH)) u_cnt (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .flush_i   (bus.flush_i),
            .req_num_i (req_num[g*NW +: NW]),
            .release_i (bus.rs_release_i[g]),
            .credit_o  (credit[g*CW +: CW])
        );
    end
    assign bus.grant_o   = grant;
    assign bus.req_o     = req;
    assign bus.req_num_o = req_num;
    assign bus.credit_o  = credit;
    assign bus.stall_o   = |(bus.inst_valid_i & ~grant) & ~bus.flush_i;
endmodule

// File: tb/tb_rs_credit_dispatcher.sv
// tb_rs_credit_dispatcher: scoreboard bench with a slot-level reference model, directed scenarios and random traffic
module tb_rs_credit_dispatcher;
    import rs_credit_dispatcher_pkg::*;
    localparam int DW = 2, NR = 4, D = 8, SW = 3, NW = 2, CW = 4;
`ifdef RS_CREDIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct packed {
        logic [DW-1:0]    grant;
        logic             stall;
        logic [DW*NR-1:0] req;
        logic [NR*NW-1:0] req_num;
        logic [NR*CW-1:0] credit;
    } exp_t;
    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   mcred[NR] = '{D, D, D, D};
    rs_credit_dispatcher_if #(.DISPATCH_WIDTH(DW), .NUM_RS(NR), .RS_DEPTH(D), .SEL_W(SW)) bus ();
    rs_credit_dispatcher #(.DISPATCH_WIDTH(DW), .NUM_RS(NR), .RS_DEPTH(D), .SEL_W(SW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    // Drive one cycle of stimulus, predict the response from the model, then advance the model
    task automatic step(input logic [DW-1:0] v, input logic [DW*SW-1:0] ty, input logic [NR-1:0] rel, input logic fl, input logic rs);
        exp_t e;
        int   used[NR];
        bit   open;
        int   code, r, nxt;
        @(posedge clk_i);
        #1;
        reset_i = rs;
        bus.flush_i = fl;
        bus.inst_valid_i = v;
        bus.inst_rs_type_i = ty;
        bus.rs_release_i = rel;
        e = '0;
        for (int k = 0; k < NR; k++) begin
            used[k] = 0;
            e.credit[k*CW +: CW] = CW'(mcred[k]);
        end
        open = 1'b1;
        for (int s = 0; s < DW; s++) begin
            code = int'(ty[s*SW +: SW]);
            r = (code >= 1 && code <= NR) ? code - 1 : -1;
            if (v[s]) begin
                if (open && (r < 0 || mcred[(r < 0) ? 0 : r] + (BYP ? int'(rel[(r < 0) ? 0 : r]) : 0) > used[(r < 0) ? 0 : r])) begin
                    e.grant[s] = 1'b1;
                    if (r >= 0) begin
                        e.req[s*NR + r] = 1'b1;
                        used[r]++;
                    end
                end else begin
                    open = 1'b0;
                end
            end
        end
        if (fl) begin
            e.grant = '0;
            e.req = '0;
            for (int k = 0; k < NR; k++) used[k] = 0;
        end
        for (int k = 0; k < NR; k++) e.req_num[k*NW +: NW] = NW'(used[k]);
        e.stall = |(v & ~e.grant) && !fl;
        sb.push_back(e);
        for (int k = 0; k < NR; k++) begin
            nxt = mcred[k] - used[k] + int'(rel[k]);
            mcred[k] = (rs || fl || nxt > D) ? D : nxt;
        end
    endtask
    task automatic idle();
        step('0, '0, '0, 1'b0, 1'b0);
    endtask
    // Monitor: every mid-cycle, compare the DUT against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_grant", 32'(bus.grant_o), 32'(e.grant));
                chk("sb_stall", 32'(bus.stall_o), 32'(e.stall));
                chk("sb_req", 32'(bus.req_o), 32'(e.req));
                chk("sb_req_num", 32'(bus.req_num_o), 32'(e.req_num));
                chk("sb_credit", 32'(bus.credit_o), 32'(e.credit));
            end
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [DW-1:0]    v;
        logic [DW*SW-1:0] ty;
        logic [NR-1:0]    rel;
        logic             fl, rs;
        bus.flush_i = 1'b0;
        bus.inst_valid_i = '0;
        bus.inst_rs_type_i = '0;
        bus.rs_release_i = '0;
        step('0, '0, '0, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("reset_credit", 32'(bus.credit_o), 32'h8888);
        chk("reset_grant", 32'(bus.grant_o), 0);
        chk("reset_stall", 32'(bus.stall_o), 0);
        chk("reset_req_num", 32'(bus.req_num_o), 0);
        idle();
        step(2'b11, {RS_ENT_MUL, RS_ENT_ALU}, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("alu_mul_grant", 32'(bus.grant_o), 3);
        chk("alu_req_num", 32'(bus.req_num_o[1:0]), 1);
        chk("mul_req_num", 32'(bus.req_num_o[5:4]), 1);
        idle();
        @(negedge clk_i);
        chk("alu_credit7", 32'(bus.credit_o[3:0]), 7);
        chk("mul_credit7", 32'(bus.credit_o[11:8]), 7);
        repeat (3) step(2'b11, {RS_ENT_LDST, RS_ENT_LDST}, '0, 1'b0, 1'b0);
        step(2'b01, {RS_ENT_NONE, RS_ENT_LDST}, '0, 1'b0, 1'b0);
        step(2'b11, {RS_ENT_LDST, RS_ENT_LDST}, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("ldst1_grant", 32'(bus.grant_o), 1);
        chk("ldst1_stall", 32'(bus.stall_o), 1);
        step(2'b11, {RS_ENT_ALU, RS_ENT_LDST}, 4'b1000, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("ldst0_credit", 32'(bus.credit_o[15:12]), 0);
        chk("ldst0_rel_grant", 32'(bus.grant_o), BYP ? 3 : 0);
        chk("ldst0_rel_stall", 32'(bus.stall_o), BYP ? 0 : 1);
        idle();
        @(negedge clk_i);
        chk("ldst_after_rel", 32'(bus.credit_o[15:12]), BYP ? 0 : 1);
        step(2'b10, {RS_ENT_BRANCH, RS_ENT_NONE}, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("hole_grant", 32'(bus.grant_o), 2);
        chk("hole_stall", 32'(bus.stall_o), 0);
        step(2'b11, {RS_ENT_ALU, RS_ENT_ALU}, 4'b0010, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("flush_grant", 32'(bus.grant_o), 0);
        chk("flush_stall", 32'(bus.stall_o), 0);
        chk("flush_req", 32'(bus.req_o), 0);
        idle();
        @(negedge clk_i);
        chk("flush_credit", 32'(bus.credit_o), 32'h8888);
        step('0, '0, 4'b0001, 1'b0, 1'b0);
        idle();
        @(negedge clk_i);
        chk("sat_alu_credit", 32'(bus.credit_o[3:0]), 8);
        repeat (4) step(2'b11, {RS_ENT_MUL, RS_ENT_MUL}, '0, 1'b0, 1'b0);
        step(2'b11, {RS_ENT_MUL, RS_ENT_MUL}, '0, 1'b0, 1'b1);
        @(negedge clk_i);
        chk("rst_stall_grant", 32'(bus.grant_o), 0);
        chk("rst_stall_stall", 32'(bus.stall_o), 1);
        step(2'b11, {RS_ENT_MUL, RS_ENT_MUL}, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("rst_restore_grant", 32'(bus.grant_o), 3);
        chk("rst_restore_credit", 32'(bus.credit_o), 32'h8888);
        repeat (400) begin
            v = DW'($urandom);
            for (int s = 0; s < DW; s++) ty[s*SW +: SW] = SW'($urandom_range(0, 7));
            for (int k = 0; k < NR; k++) rel[k] = mcred[k] < D && $urandom_range(0, 2) == 0;
            fl = $urandom_range(0, 24) == 0;
            rs = $urandom_range(0, 59) == 0;
            step(v, ty, rel, fl, rs);
        end
        idle();
        for (int n = 0; n < 5 && sb.size() > 0; n++) @(negedge clk_i);
        #1;
        if (sb.size() > 0) chk("sb_drain", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
